register_file_multiport: RTL

Parametrised general-purpose register file for the single-cycle and upcoming pipelined MIPS datapaths. Generalises the register bank to configurable data width, depth and read-port count, and adds three features: a post-reset clearing sequencer, same-cycle write-to-read bypass, and a per-register pending scoreboard for pipeline hazard detection. It sits between instruction decode (read addresses, reservations) and write-back (write port).

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/register_file_multiport.sv | 127 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file and its scoreboard.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  // Low bit of port `port` inside a packed bus of `w`-bit slices.
  function automatic int port_lo(input int port, input int w);
    return port * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for hazard detection; a write clears, a reservation sets.
// Lookups are combinational from the registered bits; updates land on the next edge.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD-1:0]        rd_pending
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pending_q, pending_d;

  // Reservation is applied after the write so a same-cycle new producer wins.
  always_comb begin
    pending_d = pending_q;
    if (enable) begin
      if (wr_en)  pending_d[wr_addr]  = 1'b0;
      if (rsv_en) pending_d[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  always_comb begin
    rd_pending = '0;
    for (int i = 0; i < N_RD; i++) begin
      rd_pending[i] = pending_q[rd_addr[port_lo(i, ADDR_W) +: ADDR_W]];
    end
  end

endmodule

// File: rtl/register_file_multiport.sv
// Multiport register file with post-reset clearing, write-to-read bypass and pending scoreboard.
// Reads are combinational; writes visible next cycle (same cycle with BYPASS); ready DEPTH edges after reset.
module register_file_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_pending,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   ready
);

  localparam int DEPTH = 1 << ADDR_W;

  rf_state_t          state_q, state_d;
  logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               wr_zero;
  logic [N_RD-1:0]    sb_pending;

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      RF_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = RF_READY;
      end
      RF_READY: state_d = RF_READY;
      default:  state_d = RF_CLEAR;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state_q)
      RF_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
      end
      RF_READY: begin
        ready  = 1'b1;
        mem_we = wr_en && !wr_zero;
      end
      default: ;
    endcase
  end

  // No reset on the array so it can map onto RAM/LUT storage.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .N_RD     (N_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rd_addr    (rd_addr),
    .rd_pending (sb_pending)
  );

  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    for (int i = 0; i < N_RD; i++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              p;
      a = rd_addr[port_lo(i, ADDR_W) +: ADDR_W];
      d = mem_q[a];
      p = sb_pending[i];
      if ((ZERO_REG != 0) && (a == '0)) begin
        d = '0;
        p = 1'b0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == a)) begin
        d = wr_data;
        p = 1'b0;
      end
      if (!ready) begin
        d = '0;
        p = 1'b0;
      end
      rd_data[port_lo(i, DATA_W) +: DATA_W] = d;
      rd_pending[i]                         = p;
    end
  end

endmodule
